// File: rtl/game_round_ctrl.sv
// Round sequencer for TOM-JERRY: start countdown, round timer and catch detection.
// Drives the reset/over inputs of both player movement controllers.
module game_round_ctrl #(
    parameter int TICKS_PER_SEC     = 65_000_000,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int ROUND_SECONDS     = 60,
    parameter int TOM_WIDTH         = 64,
    parameter int TOM_HEIGHT        = 64,
    parameter int JERRY_WIDTH       = 32,
    parameter int JERRY_HEIGHT      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] tom_x,
    input  logic [9:0] tom_y,
    input  logic [9:0] jerry_x,
    input  logic [9:0] jerry_y,
    output logic       round_reset,
    output logic       round_over,
    output logic [1:0] state,
    output logic [2:0] countdown,
    output logic [6:0] time_left,
    output logic       winner
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        OVER      = 2'd3
    } state_t;

    localparam logic [26:0] TICK_MAX   = 27'(TICKS_PER_SEC - 1);
    localparam logic [2:0]  CD_INIT    = 3'(COUNTDOWN_SECONDS);
    localparam logic [6:0]  ROUND_INIT = 7'(ROUND_SECONDS);

    state_t      state_q, state_d;
    logic        start_q, start_rise_q;
    logic [26:0] tick_cnt, tick_d;
    logic        sec_pulse;
    logic        overlap, catch_q;
    logic [2:0]  countdown_d;
    logic [6:0]  time_left_d;
    logic        winner_d, round_reset_d, round_over_d;

    // 11-bit sums so boxes at the right/bottom screen edge cannot wrap around
    logic [10:0] tom_x_end, tom_y_end, jerry_x_end, jerry_y_end;

    assign tom_x_end   = {1'b0, tom_x}   + 11'(TOM_WIDTH);
    assign tom_y_end   = {1'b0, tom_y}   + 11'(TOM_HEIGHT);
    assign jerry_x_end = {1'b0, jerry_x} + 11'(JERRY_WIDTH);
    assign jerry_y_end = {1'b0, jerry_y} + 11'(JERRY_HEIGHT);

    assign overlap = ({1'b0, tom_x}   < jerry_x_end) &&
                     ({1'b0, jerry_x} < tom_x_end)   &&
                     ({1'b0, tom_y}   < jerry_y_end) &&
                     ({1'b0, jerry_y} < tom_y_end);

    assign sec_pulse = (tick_cnt == TICK_MAX);
    assign state     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b1;
            start_rise_q <= 1'b0;
            tick_cnt     <= '0;
            catch_q      <= 1'b0;
            round_reset  <= 1'b1;
            round_over   <= 1'b0;
            countdown    <= '0;
            time_left    <= ROUND_INIT;
            winner       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            start_rise_q <= start & ~start_q;
            tick_cnt     <= tick_d;
            catch_q      <= overlap;
            round_reset  <= round_reset_d;
            round_over   <= round_over_d;
            countdown    <= countdown_d;
            time_left    <= time_left_d;
            winner       <= winner_d;
        end
    end

    // A catch in PLAY takes priority over the timer, so time_left freezes on a catch
    always_comb begin
        state_d     = state_q;
        tick_d      = '0;
        countdown_d = countdown;
        time_left_d = time_left;
        winner_d    = winner;

        case (state_q)
            IDLE, OVER: begin
                if (start_rise_q) begin
                    state_d     = COUNTDOWN;
                    countdown_d = CD_INIT;
                    time_left_d = ROUND_INIT;
                    winner_d    = 1'b0;
                end
            end
            COUNTDOWN: begin
                tick_d = sec_pulse ? '0 : tick_cnt + 27'd1;
                if (sec_pulse) begin
                    countdown_d = countdown - 3'd1;
                    if (countdown == 3'd1) begin
                        state_d     = PLAY;
                        countdown_d = '0;
                        time_left_d = ROUND_INIT;
                    end
                end
            end
            PLAY: begin
                tick_d = sec_pulse ? '0 : tick_cnt + 27'd1;
                if (catch_q) begin
                    state_d  = OVER;
                    winner_d = 1'b1;
                end else if (sec_pulse) begin
                    time_left_d = time_left - 7'd1;
                    if (time_left == 7'd1) begin
                        state_d  = OVER;
                        winner_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        round_reset_d = (state_d == IDLE) || (state_d == COUNTDOWN);
        round_over_d  = (state_d == OVER);
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: scoreboard of expected output records
// plus a table of bounding-box vectors applied at the start of PLAY.
module tb_game_round_ctrl;

    localparam int TPS = 10;
    localparam int CDS = 3;
    localparam int RS  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] tom_x, tom_y, jerry_x, jerry_y;
    logic       round_reset, round_over, winner;
    logic [1:0] state;
    logic [2:0] countdown;
    logic [6:0] time_left;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       rr;
        logic       ro;
        logic [2:0] cd;
        logic [6:0] tl;
        logic       w;
    } exp_t;

    typedef struct {
        logic [9:0] tx;
        logic [9:0] ty;
        logic [9:0] jx;
        logic [9:0] jy;
        logic       caught;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[11];
    int   check_count = 0;
    int   pass_count  = 0;

    always #5 clk = ~clk;

    game_round_ctrl #(
        .TICKS_PER_SEC    (TPS),
        .COUNTDOWN_SECONDS(CDS),
        .ROUND_SECONDS    (RS),
        .TOM_WIDTH        (64),
        .TOM_HEIGHT       (64),
        .JERRY_WIDTH      (32),
        .JERRY_HEIGHT     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tom_x      (tom_x),
        .tom_y      (tom_y),
        .jerry_x    (jerry_x),
        .jerry_y    (jerry_y),
        .round_reset(round_reset),
        .round_over (round_over),
        .state      (state),
        .countdown  (countdown),
        .time_left  (time_left),
        .winner     (winner)
    );

    task automatic applyStimulus(input logic [9:0] tx, input logic [9:0] ty,
                                 input logic [9:0] jx, input logic [9:0] jy,
                                 input logic st);
        tom_x   = tx;
        tom_y   = ty;
        jerry_x = jx;
        jerry_y = jy;
        start   = st;
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expectOut(input string tag, input logic [1:0] st, input logic rr,
                             input logic ro, input logic [2:0] cd, input logic [6:0] tl,
                             input logic w);
        exp_t e;
        e.tag = tag; e.st = st; e.rr = rr; e.ro = ro; e.cd = cd; e.tl = tl; e.w = w;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        check_count++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got no expected record, required one");
            return;
        end
        e = exp_q.pop_front();
        if ({state, round_reset, round_over, countdown, time_left, winner} ===
            {e.st, e.rr, e.ro, e.cd, e.tl, e.w})
            pass_count++;
        else
            $display("[TB] FAIL %s: got st=%0d rr=%0b ro=%0b cd=%0d tl=%0d w=%0b, required st=%0d rr=%0b ro=%0b cd=%0d tl=%0d w=%0b",
                     e.tag, state, round_reset, round_over, countdown, time_left, winner,
                     e.st, e.rr, e.ro, e.cd, e.tl, e.w);
    endtask

    task automatic check_now(input string tag, input logic [1:0] st, input logic rr,
                             input logic ro, input logic [2:0] cd, input logic [6:0] tl,
                             input logic w);
        expectOut(tag, st, rr, ro, cd, tl, w);
        checkOutput();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        applyStimulus(10'd0, 10'd0, 10'd500, 10'd400, 1'b0);
        cycle(2);
        rst = 1'b0;
        cycle(1);
    endtask

    // Leaves the bench at the first negedge after COUNTDOWN is entered
    task automatic start_round();
        start = 1'b1;
        cycle(2);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish by 1000000, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{10'd100,  10'd100, 10'd164,  10'd100, 1'b0};
        vecs[1]  = '{10'd100,  10'd100, 10'd163,  10'd100, 1'b1};
        vecs[2]  = '{10'd100,  10'd100, 10'd68,   10'd100, 1'b0};
        vecs[3]  = '{10'd100,  10'd100, 10'd69,   10'd100, 1'b1};
        vecs[4]  = '{10'd100,  10'd100, 10'd100,  10'd164, 1'b0};
        vecs[5]  = '{10'd100,  10'd100, 10'd100,  10'd68,  1'b0};
        vecs[6]  = '{10'd100,  10'd100, 10'd120,  10'd120, 1'b1};
        vecs[7]  = '{10'd1000, 10'd1000, 10'd1023, 10'd1023, 1'b1};
        vecs[8]  = '{10'd0,    10'd0,   10'd64,   10'd0,   1'b0};
        vecs[9]  = '{10'd963,  10'd500, 10'd1023, 10'd500, 1'b1};
        vecs[10] = '{10'd100,  10'd100, 10'd163,  10'd164, 1'b0};

        // Full timeout round from reset
        rst = 1'b1;
        applyStimulus(10'd0, 10'd0, 10'd500, 10'd400, 1'b0);
        cycle(2);
        check_now("reset_values", 2'd0, 1'b1, 1'b0, 3'd0, 7'd5, 1'b0);
        rst = 1'b0;
        cycle(1);
        start = 1'b1;
        cycle(1);
        check_now("start_rise_latency", 2'd0, 1'b1, 1'b0, 3'd0, 7'd5, 1'b0);
        cycle(1);
        check_now("enter_countdown", 2'd1, 1'b1, 1'b0, 3'd3, 7'd5, 1'b0);
        start = 1'b0;
        for (int i = 1; i < 30; i++) begin
            expectOut($sformatf("countdown_c%0d", i), 2'd1, 1'b1, 1'b0, 3'(3 - i / 10), 7'd5, 1'b0);
            cycle(1);
            checkOutput();
        end
        expectOut("enter_play", 2'd2, 1'b0, 1'b0, 3'd0, 7'd5, 1'b0);
        cycle(1);
        checkOutput();
        for (int j = 1; j < 50; j++) begin
            expectOut($sformatf("play_c%0d", j), 2'd2, 1'b0, 1'b0, 3'd0, 7'(5 - j / 10), 1'b0);
            cycle(1);
            checkOutput();
        end
        expectOut("timeout_over", 2'd3, 1'b0, 1'b1, 3'd0, 7'd0, 1'b0);
        cycle(1);
        checkOutput();
        cycle(5);
        check_now("over_hold", 2'd3, 1'b0, 1'b1, 3'd0, 7'd0, 1'b0);

        // Restart from OVER, with start toggling through COUNTDOWN and PLAY
        start = 1'b1;
        cycle(2);
        check_now("restart_from_over", 2'd1, 1'b1, 1'b0, 3'd3, 7'd5, 1'b0);
        for (int i = 1; i < 30; i++) begin
            start = (i % 3 == 0);
            expectOut($sformatf("cd_toggle_c%0d", i), 2'd1, 1'b1, 1'b0, 3'(3 - i / 10), 7'd5, 1'b0);
            cycle(1);
            checkOutput();
        end
        start = 1'b0;
        expectOut("play_after_toggle", 2'd2, 1'b0, 1'b0, 3'd0, 7'd5, 1'b0);
        cycle(1);
        checkOutput();
        for (int k = 0; k < 4; k++) begin
            start = (k % 2 == 1);
            expectOut($sformatf("play_toggle_c%0d", k), 2'd2, 1'b0, 1'b0, 3'd0, 7'd5, 1'b0);
            cycle(1);
            checkOutput();
        end
        applyStimulus(10'd100, 10'd100, 10'd164, 10'd100, 1'b0);
        cycle(3);
        check_now("touching_no_catch", 2'd2, 1'b0, 1'b0, 3'd0, 7'd5, 1'b0);
        applyStimulus(10'd100, 10'd100, 10'd163, 10'd100, 1'b0);
        cycle(1);
        check_now("catch_pipeline_1", 2'd2, 1'b0, 1'b0, 3'd0, 7'd5, 1'b0);
        cycle(1);
        check_now("catch_over", 2'd3, 1'b0, 1'b1, 3'd0, 7'd5, 1'b1);
        cycle(15);
        check_now("catch_frozen", 2'd3, 1'b0, 1'b1, 3'd0, 7'd5, 1'b1);

        // Catch in the same cycle as the final second pulse
        reset_dut();
        start_round();
        cycle(30);
        check_now("race_play_entry", 2'd2, 1'b0, 1'b0, 3'd0, 7'd5, 1'b0);
        cycle(48);
        check_now("race_last_second", 2'd2, 1'b0, 1'b0, 3'd0, 7'd1, 1'b0);
        applyStimulus(10'd100, 10'd100, 10'd120, 10'd120, 1'b0);
        cycle(1);
        check_now("race_pre", 2'd2, 1'b0, 1'b0, 3'd0, 7'd1, 1'b0);
        cycle(1);
        check_now("race_catch_wins", 2'd3, 1'b0, 1'b1, 3'd0, 7'd1, 1'b1);

        // start held through reset release
        rst = 1'b1;
        applyStimulus(10'd0, 10'd0, 10'd500, 10'd400, 1'b1);
        cycle(2);
        rst = 1'b0;
        cycle(5);
        check_now("held_start_idle", 2'd0, 1'b1, 1'b0, 3'd0, 7'd5, 1'b0);
        start = 1'b0;
        cycle(2);
        start = 1'b1;
        cycle(2);
        check_now("press_after_release", 2'd1, 1'b1, 1'b0, 3'd3, 7'd5, 1'b0);
        start = 1'b0;

        // Asynchronous reset mid-PLAY
        cycle(30);
        cycle(15);
        check_now("mid_play", 2'd2, 1'b0, 1'b0, 3'd0, 7'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_now("async_reset", 2'd0, 1'b1, 1'b0, 3'd0, 7'd5, 1'b0);
        cycle(2);
        rst = 1'b0;
        cycle(1);

        // Bounding-box table, each vector applied on the first PLAY cycle
        for (int v = 0; v < 11; v++) begin
            reset_dut();
            start_round();
            cycle(30);
            applyStimulus(vecs[v].tx, vecs[v].ty, vecs[v].jx, vecs[v].jy, 1'b0);
            expectOut($sformatf("aabb_%0d", v), vecs[v].caught ? 2'd3 : 2'd2, 1'b0,
                      vecs[v].caught, 3'd0, 7'd5, vecs[v].caught);
            cycle(2);
            checkOutput();
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the TOM-JERRY game. It drives the `reset` and `over` inputs of both player movement controllers. It runs the start countdown and the round timer, and detects when Tom catches Jerry using a bounding-box test on the player coordinates. It sits in the top-level game core, between the button debouncers, the player movement controllers, and the HUD/text renderer.

## Interface
Parameters:
- TICKS_PER_SEC, 65_000_000 — clk cycles per game second
- COUNTDOWN_SECONDS, 3 — pre-round countdown length, range 1..7
- ROUND_SECONDS, 60 — round length, range 1..127
- TOM_WIDTH, 64 / TOM_HEIGHT, 64 — Tom bounding box in pixels
- JERRY_WIDTH, 32 / JERRY_HEIGHT, 32 — Jerry bounding box in pixels

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  debounced start button, level
- tom_x, tom_y  in  10 each  Tom top-left coordinates
- jerry_x, jerry_y  in  10 each  Jerry top-left coordinates
- round_reset  out  1  high while players must sit at spawn; drives `reset` of movement controllers
- round_over  out  1  high after the round ends; drives `over` of movement controllers
- state  out  2  0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=OVER
- countdown  out  3  seconds left in COUNTDOWN, 0 elsewhere
- time_left  out  7  seconds left in the round
- winner  out  1  0=Jerry survived, 1=Tom caught Jerry; valid in OVER

## Operation
- All outputs are registered. Reset values: state=IDLE, round_reset=1, round_over=0, countdown=0, time_left=ROUND_SECONDS, winner=0.
- Start edge: start_q is registered every cycle. start_rise = start & ~start_q. start_q resets to 1, so a button held through reset does not start a round.
- Second tick: a 27-bit tick_cnt runs only in COUNTDOWN and PLAY and is cleared to 0 on entry to either state. sec_pulse = (tick_cnt == TICKS_PER_SEC-1). On that cycle tick_cnt wraps to 0.
- Catch: AABB overlap with strict inequalities and 11-bit sums (no wrap):
  - tom_x < jerry_x+JERRY_WIDTH
  - jerry_x < tom_x+TOM_WIDTH
  - tom_y < jerry_y+JERRY_HEIGHT
  - jerry_y < tom_y+TOM_HEIGHT
  - The result is registered into catch_q. Touching edges do not count as a catch.
- FSM:
  - IDLE: round_reset=1, round_over=0. On start_rise go to COUNTDOWN with countdown=COUNTDOWN_SECONDS, time_left=ROUND_SECONDS, winner=0.
  - COUNTDOWN: round_reset=1. On sec_pulse, decrement countdown. If countdown==1 at the pulse, go to PLAY with countdown=0 and time_left=ROUND_SECONDS. start is ignored.
  - PLAY: round_reset=0, round_over=0.
    - catch_q=1 → OVER, winner=1, time_left frozen.
    - Otherwise, on sec_pulse, decrement time_left. If time_left was 1, go to OVER with time_left=0 and winner=0.
    - If catch_q and the final sec_pulse occur in the same cycle, the catch wins: winner=1, time_left stays 1.
  - OVER: round_reset=0, round_over=1. winner and time_left are held. On start_rise go to COUNTDOWN and initialise as from IDLE.
- catch_q is ignored outside PLAY. catch_q from the first PLAY cycle counts, so players overlapping at spawn end the round immediately; spawn points must not overlap.
- rst mid-round returns to reset values immediately and asynchronously.

## Timing
- start_rise is seen 1 cycle after start rises. state changes on the next edge, so COUNTDOWN is visible 2 cycles after start rises.
- COUNTDOWN lasts exactly COUNTDOWN_SECONDS*TICKS_PER_SEC cycles.
- round_reset falls on the same edge that state becomes PLAY.
- A catch ends the round 2 cycles after the coordinates first overlap: one cycle for catch_q, one for the state register.
- A timeout round lasts exactly ROUND_SECONDS*TICKS_PER_SEC cycles in PLAY.
- round_over rises on the same edge that state becomes OVER.
- countdown and time_left update on the sec_pulse edge, together with any state change.

## Test plan
Benches use TICKS_PER_SEC=10, COUNTDOWN_SECONDS=3, ROUND_SECONDS=5, and Tom and Jerry boxes of 64 and 32.
- Reset then start pulse, no overlap → state 0→1 two cycles after start; countdown 3,2,1 at 10-cycle steps; PLAY after 30 cycles with round_reset 1→0; time_left 5..0; OVER after 50 PLAY cycles with winner=0 and round_over=1.
- In PLAY, tom=(100,100), jerry=(164,100) (touching edges) → no catch. Move jerry to (163,100) → state=OVER 2 cycles later, winner=1, time_left frozen.
- Overlap asserted in the cycle of the final sec_pulse → winner=1, time_left=1.
- start held through rst release → stays IDLE. Release start then press → COUNTDOWN. start toggled during COUNTDOWN and PLAY → ignored.
- In OVER, press start → COUNTDOWN; countdown=3, time_left=5, winner=0, round_over=0, round_reset=1.
- Assert rst mid-PLAY → all outputs at reset values immediately, before the next clk edge.
